// File: rtl/j1_io_pkg.sv
// Shared definitions for peripherals on the j1 registered I/O bus.
// Address bits 0..13 belong to the existing peripherals; the SPI master owns 14 and 15.
package j1_io_pkg;

    localparam int DATA_BIT = 14;
    localparam int CTRL_BIT = 15;

    localparam int STAT_CS_EN    = 0;
    localparam int STAT_BUSY     = 1;
    localparam int STAT_RX_VALID = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_master.sv
// Byte-wide mode-0 SPI master on the j1 registered I/O bus.
// One write to the data register shifts a byte out MSB first while shifting MISO in.
module spi_master #(
    parameter int DATA_BIT = j1_io_pkg::DATA_BIT,
    parameter int CTRL_BIT = j1_io_pkg::CTRL_BIT,
    parameter int HALF     = 1
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [15:0] io_addr,
    input  logic [15:0] dout,
    output logic [15:0] io_din,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_csn
);
    import j1_io_pkg::*;

    localparam logic [7:0] HALF_M1 = 8'(HALF - 1);

    spi_state_e state_q, state_d;
    logic       cs_en_q, cs_en_d;
    logic       csn_q, csn_d;
    logic       busy_q, busy_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] div_q, div_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;

    logic data_wr, ctrl_wr, data_rd;
    assign data_wr = io_wr & io_addr[DATA_BIT];
    assign ctrl_wr = io_wr & io_addr[CTRL_BIT];
    assign data_rd = io_rd & io_addr[DATA_BIT];

    logic unused_bits;
    assign unused_bits = ^{dout[15:8], io_addr};

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q    <= IDLE;
            cs_en_q    <= 1'b0;
            csn_q      <= 1'b1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'd0;
            shreg_q    <= 8'd0;
            bitcnt_q   <= 3'd0;
            div_q      <= 8'd0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_en_q    <= cs_en_d;
            csn_q      <= csn_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            div_q      <= div_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cs_en_d    = cs_en_q;
        csn_d      = csn_q;
        busy_d     = busy_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        div_d      = div_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;

        if (ctrl_wr) begin
            cs_en_d = dout[0];
            csn_d   = ~dout[0];
        end
        // The clear comes first so a completion on the same edge overrides it.
        if (data_rd) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (data_wr) begin
                    shreg_d    = dout[7:0];
                    mosi_d     = dout[7];
                    bitcnt_d   = 3'd7;
                    div_d      = HALF_M1;
                    busy_d     = 1'b1;
                    rx_valid_d = 1'b0;
                    state_d    = LOW;
                end
            end
            LOW: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else begin
                    sck_d   = 1'b1;
                    shreg_d = {shreg_q[6:0], spi_miso};
                    div_d   = HALF_M1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else begin
                    sck_d = 1'b0;
                    if (bitcnt_q == 3'd0) begin
                        rx_data_d  = shreg_q;
                        busy_d     = 1'b0;
                        rx_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        bitcnt_d = bitcnt_q - 3'd1;
                        mosi_d   = shreg_q[7];
                        div_d    = HALF_M1;
                        state_d  = LOW;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [15:0] status;
    always_comb begin
        status                = 16'd0;
        status[STAT_CS_EN]    = cs_en_q;
        status[STAT_BUSY]     = busy_q;
        status[STAT_RX_VALID] = rx_valid_q;
    end

    always_comb begin
        io_din = 16'd0;
        if (io_addr[DATA_BIT]) begin
            io_din = io_din | {8'd0, rx_data_q};
        end
        if (io_addr[CTRL_BIT]) begin
            io_din = io_din | status;
        end
    end

    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_csn  = csn_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a HALF=1 loopback instance and a HALF=4 instance with a slave model.
module tb_spi_master;

    localparam logic [15:0] A_DATA = 16'h4000;
    localparam logic [15:0] A_CTRL = 16'h8000;

    logic clk = 1'b0;
    logic resetq = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] io_addr = 16'd0;
    logic [15:0] dout = 16'd0;
    logic wr1 = 1'b0, wr4 = 1'b0, rd1 = 1'b0, rd4 = 1'b0;
    logic [15:0] din1, din4;
    logic sck1, mosi1, csn1, miso1;
    logic sck4, mosi4, csn4, miso4;

    spi_master #(.HALF(1)) u1 (
        .clk(clk), .resetq(resetq), .io_wr(wr1), .io_rd(rd1), .io_addr(io_addr),
        .dout(dout), .io_din(din1), .spi_sck(sck1), .spi_mosi(mosi1),
        .spi_miso(miso1), .spi_csn(csn1)
    );

    spi_master #(.HALF(4)) u4 (
        .clk(clk), .resetq(resetq), .io_wr(wr4), .io_rd(rd4), .io_addr(io_addr),
        .dout(dout), .io_din(din4), .spi_sck(sck4), .spi_mosi(mosi4),
        .spi_miso(miso4), .spi_csn(csn4)
    );

    assign miso1 = mosi1;

    int cyc = 0;
    int rises1 = 0, rises4 = 0, falls4 = 0;
    logic [7:0] cap1 = 8'd0, cap4 = 8'd0;
    logic [7:0] pat4 = 8'd0;
    int base4 = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge sck1) begin
        rises1 <= rises1 + 1;
        cap1   <= {cap1[6:0], mosi1};
    end
    always @(posedge sck4) begin
        rises4 <= rises4 + 1;
        cap4   <= {cap4[6:0], mosi4};
    end
    always @(negedge sck4) falls4 <= falls4 + 1;

    // Slave presents the next pattern bit after each falling SCK edge.
    assign miso4 = ((falls4 - base4) < 8) ? pat4[3'(7 - (falls4 - base4))] : 1'b0;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic bus_write(input int sel, input logic [15:0] a, input logic [15:0] d);
        io_addr = a;
        dout    = d;
        if (sel == 0) wr1 = 1'b1; else wr4 = 1'b1;
        @(posedge clk); #1;
        wr1 = 1'b0; wr4 = 1'b0; io_addr = 16'd0;
    endtask

    task automatic bus_read(input int sel, input logic [15:0] a, output logic [15:0] v);
        io_addr = a;
        if (sel == 0) rd1 = 1'b1; else rd4 = 1'b1;
        #1;
        v = (sel == 0) ? din1 : din4;
        @(posedge clk); #1;
        rd1 = 1'b0; rd4 = 1'b0; io_addr = 16'd0;
    endtask

    task automatic peek(input int sel, input logic [15:0] a, output logic [15:0] v);
        io_addr = a;
        #1;
        v = (sel == 0) ? din1 : din4;
        io_addr = 16'd0;
    endtask

    task automatic wait_idle(input int sel, output int endc);
        int n;
        logic [15:0] v;
        n = 0;
        peek(sel, A_CTRL, v);
        while (v[1] && n < 2000) begin
            @(posedge clk); #1;
            n++;
            peek(sel, A_CTRL, v);
        end
        endc = cyc;
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL busy_timeout actual=busy required=idle");
        end
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] pat;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vt[4];
    logic [7:0] lb[2];

    initial begin
        logic [15:0] v;
        int s, e, r0, n;

        vt[0] = '{8'hFF, 8'h3C, 8'h3C};
        vt[1] = '{8'h00, 8'hFF, 8'hFF};
        vt[2] = '{8'hA5, 8'h5A, 8'h5A};
        vt[3] = '{8'h81, 8'h01, 8'h01};
        lb[0] = 8'hA5;
        lb[1] = 8'h3C;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_csn1", 32'(csn1), 32'h1);
        check("rst_sck1", 32'(sck1), 32'h0);
        check("rst_csn4", 32'(csn4), 32'h1);
        check("rst_mosi4", 32'(mosi4), 32'h0);
        resetq = 1'b1;
        @(posedge clk); #1;
        bus_read(0, A_CTRL, v);
        check("rst_ctrl1", 32'(v), 32'h0);
        bus_read(1, A_CTRL | A_DATA, v);
        check("rst_both4", 32'(v), 32'h0);

        // Loopback on HALF=1
        bus_write(0, A_CTRL, 16'h0001);
        check("lb_csn_low", 32'(csn1), 32'h0);
        for (int i = 0; i < 2; i++) begin
            r0 = rises1;
            bus_write(0, A_DATA, {8'd0, lb[i]});
            s = cyc;
            check("lb_mosi_bit7", 32'(mosi1), 32'(lb[i][7]));
            wait_idle(0, e);
            check("lb_dur", 32'(e - s), 32'd16);
            check("lb_rises", 32'(rises1 - r0), 32'd8);
            check("lb_mosi_bits", 32'(cap1), 32'(lb[i]));
            bus_read(0, A_CTRL, v);
            check("lb_ctrl_done", 32'(v), 32'h5);
            bus_read(0, A_DATA, v);
            check("lb_rx", 32'(v), 32'(lb[i]));
            bus_read(0, A_CTRL, v);
            check("lb_ctrl_clr", 32'(v), 32'h1);
        end

        // Slave pattern table on HALF=4
        for (int i = 0; i < 4; i++) begin
            pat4  = vt[i].pat;
            base4 = falls4;
            r0    = rises4;
            bus_write(1, A_DATA, {8'd0, vt[i].tx});
            s = cyc;
            wait_idle(1, e);
            check("tab_dur", 32'(e - s), 32'd64);
            check("tab_rises", 32'(rises4 - r0), 32'd8);
            check("tab_mosi", 32'(cap4), 32'(vt[i].tx));
            check("tab_sck_idle", 32'(sck4), 32'h0);
            bus_read(1, A_CTRL, v);
            check("tab_ctrl", 32'(v), 32'h4);
            bus_read(1, A_DATA | A_CTRL, v);
            check("tab_or_mux", 32'(v), 32'({8'd0, vt[i].exp_rx} | 16'h4));
            bus_read(1, A_CTRL, v);
            check("tab_ctrl_clr", 32'(v), 32'h0);
        end

        // Write while busy is ignored
        pat4  = 8'h00;
        base4 = falls4;
        r0    = rises4;
        bus_write(1, A_DATA, 16'h0081);
        s = cyc;
        repeat (3) @(posedge clk);
        #1;
        bus_write(1, A_DATA, 16'h0042);
        wait_idle(1, e);
        check("wwb_dur", 32'(e - s), 32'd64);
        check("wwb_rises", 32'(rises4 - r0), 32'd8);
        check("wwb_mosi", 32'(cap4), 32'h81);
        check("wwb_mosi_hold", 32'(mosi4), 32'h1);

        // Chip select dropped mid-transfer
        bus_write(1, A_CTRL, 16'h0001);
        pat4  = 8'hC3;
        base4 = falls4;
        bus_write(1, A_DATA, 16'h005A);
        s = cyc;
        repeat (20) @(posedge clk);
        #1;
        check("cs_mid_low", 32'(csn4), 32'h0);
        bus_write(1, A_CTRL, 16'h0000);
        check("cs_mid_high", 32'(csn4), 32'h1);
        wait_idle(1, e);
        check("cs_mid_dur", 32'(e - s), 32'd64);
        bus_read(1, A_DATA, v);
        check("cs_mid_rx", 32'(v), 32'hC3);

        // Reset mid-transfer
        bus_write(1, A_CTRL, 16'h0001);
        pat4  = 8'hFF;
        base4 = falls4;
        r0    = rises4;
        bus_write(1, A_DATA, 16'h00F0);
        n = 0;
        while ((rises4 - r0) < 4 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("rm_reached_bit3", 32'(sck4), 32'h1);
        resetq = 1'b0;
        #1;
        check("rm_sck", 32'(sck4), 32'h0);
        check("rm_csn", 32'(csn4), 32'h1);
        peek(1, A_CTRL, v);
        check("rm_ctrl_in_rst", 32'(v), 32'h0);
        @(posedge clk); #1;
        resetq = 1'b1;
        @(posedge clk); #1;
        bus_read(1, A_CTRL, v);
        check("rm_ctrl_after", 32'(v), 32'h0);
        bus_read(1, A_DATA, v);
        check("rm_rx_discard", 32'(v), 32'h0);

        // DATA read strobe on the completion edge
        bus_write(0, A_DATA, 16'h0066);
        repeat (15) @(posedge clk);
        #1;
        bus_read(0, A_DATA, v);
        check("col_rx_before", 32'(v), 32'h0);
        peek(0, A_CTRL, v);
        check("col_valid_kept", 32'(v), 32'h4);
        bus_read(0, A_DATA, v);
        check("col_rx", 32'(v), 32'h66);
        bus_read(0, A_CTRL, v);
        check("col_ctrl_clr", 32'(v), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
